// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional ILLEGAL_TRAP_EN: unsupported opcodes lock the FSM in TRAP (Illegal=1) until reset.
module multicycle_control_fsm #(
    parameter int unsigned OP_WIDTH     = 7,
    parameter int unsigned STATE_WIDTH  = 4,
    parameter int unsigned ImmSrc_width = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [OP_WIDTH-1:0]     OP,
    input  logic                    Zero,
    input  logic                    MemReady,
    output logic                    PCWrite,
    output logic                    AdrSrc,
    output logic                    MemWrite,
    output logic                    IRWrite,
    output logic [1:0]              ResultSrc,
    output logic [1:0]              ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              ALUOp,
    output logic [ImmSrc_width-1:0] ImmSrc,
    output logic                    RegWrite,
    output logic                    Illegal
);

    localparam logic [OP_WIDTH-1:0] OP_LOAD  = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_STORE = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_ITYPE = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(7'b1100011);
    localparam logic [OP_WIDTH-1:0] OP_JAL   = OP_WIDTH'(7'b1101111);

    typedef enum logic [STATE_WIDTH-1:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BEQ,
        JAL
`ifdef ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] imm_src;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = MemReady ? DECODE : FETCH;
            DECODE: begin
                if (OP == OP_LOAD || OP == OP_STORE) begin
                    state_d = MEMADR;
                end else if (OP == OP_RTYPE) begin
                    state_d = EXECUTER;
                end else if (OP == OP_ITYPE) begin
                    state_d = EXECUTEI;
                end else if (OP == OP_BEQ) begin
                    state_d = BEQ;
                end else if (OP == OP_JAL) begin
                    state_d = JAL;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = TRAP;
`else
                    state_d = FETCH;
`endif
                end
            end
            MEMADR:   state_d = (OP == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MemReady ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = MemReady ? FETCH : MEMWRITE;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
`ifdef ILLEGAL_TRAP_EN
            TRAP:     state_d = TRAP;
`endif
            default:  state_d = FETCH;
        endcase
    end

    // Moore decode, except the MemReady-qualified fetch enables and Zero-qualified branch
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        imm_src   = 2'b00;
        RegWrite  = 1'b0;
        Illegal   = 1'b0;
        if (!RST) begin
            case (state_q)
                FETCH: begin
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = MemReady;
                    PCWrite   = MemReady;
                end
                DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    if (OP == OP_STORE) begin
                        imm_src = 2'b01;
                    end else if (OP == OP_BEQ) begin
                        imm_src = 2'b10;
                    end else if (OP == OP_JAL) begin
                        imm_src = 2'b11;
                    end
                end
                MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    imm_src = (OP == OP_STORE) ? 2'b01 : 2'b00;
                end
                MEMREAD: begin
                    AdrSrc = 1'b1;
                end
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                EXECUTER: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                EXECUTEI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                end
                BEQ: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b01;
                    imm_src = 2'b10;
                    PCWrite = Zero;
                end
                JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                TRAP: begin
                    Illegal = 1'b1;
                end
`endif
                default: begin
                    PCWrite = 1'b0;
                end
            endcase
        end
    end

    assign ImmSrc = ImmSrc_width'(imm_src);

endmodule
